adc_sample_sequencer: RTL

- Drives the command stream of the on-chip ADC core at a fixed audio sample rate and consumes its response stream.
- Converts each 12-bit unsigned conversion into a 16-bit signed, DC-centred sample.
- Presents samples on a valid/ready stream to the downstream framing/FFT stage.
- Monitors for lost ticks, downstream overrun and ADC response timeout.

---
 rtl/adc_sample_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/adc_sample_sequencer.sv
// ADC command pacer: issues one conversion per DIV-cycle tick and emits DC-centred signed samples.
// Define ADC_SEQ_AVG4_EN to emit one sample per four captures, built from their average.
module adc_sample_sequencer #(
  parameter int         DIV      = 6250,
  parameter logic [4:0] CHANNEL  = 5'd1,
  parameter int         MIDSCALE = 2048,
  parameter int         TIMEOUT  = 1023
) (
  input  logic        clock_clk,
  input  logic        reset_sink_reset_n,
  input  logic        enable,
  output logic        command_valid,
  output logic [4:0]  command_channel,
  output logic        command_startofpacket,
  output logic        command_endofpacket,
  input  logic        command_ready,
  input  logic        response_valid,
  input  logic [4:0]  response_channel,
  input  logic [11:0] response_data,
  output logic        sample_valid,
  output logic [15:0] sample_data,
  input  logic        sample_ready,
  output logic        overrun,
  output logic        timeout_err,
  input  logic        err_clr
);

  localparam logic [15:0] TICK_LAST = 16'(DIV - 1);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] MID_CODE  = 16'(MIDSCALE);

  // IDLE: wait for tick | ISSUE: hold command until accepted | WAIT_RSP: await matching response
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RSP} state_t;

  state_t      state_q, state_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        sample_valid_q, sample_valid_d;
  logic [15:0] sample_data_q, sample_data_d;
  logic        overrun_q, overrun_d;
  logic        timeout_q, timeout_d;

  logic        tick;
  logic        rsp_match;
  logic        capture;
  logic        wait_expired;
  logic        emit;
  logic        drop;
  logic        lost_tick;
  logic [11:0] cap_data;
  logic [15:0] conv_data;

  always_comb begin
    tick       = enable && (tick_cnt_q == TICK_LAST);
    tick_cnt_d = 16'd0;
    if (enable && !tick) begin
      tick_cnt_d = tick_cnt_q + 16'd1;
    end
  end

  assign rsp_match = response_valid && (response_channel == CHANNEL);

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = 16'd0;
    capture      = 1'b0;
    wait_expired = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (command_ready) state_d = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        wait_cnt_d = wait_cnt_q + 16'd1;
        if (rsp_match) begin
          capture = 1'b1;
          state_d = S_IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          wait_expired = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ADC_SEQ_AVG4_EN
  logic [13:0] acc_q, acc_d;
  logic [1:0]  phase_q, phase_d;
  logic [13:0] acc_sum;

  always_comb begin
    acc_sum  = acc_q + {2'b00, response_data};
    cap_data = acc_sum[13:2];
    acc_d    = acc_q;
    phase_d  = phase_q;
    emit     = 1'b0;
    if (wait_expired) begin
      acc_d   = 14'd0;
      phase_d = 2'd0;
    end else if (capture) begin
      if (phase_q == 2'd3) begin
        emit    = 1'b1;
        acc_d   = 14'd0;
        phase_d = 2'd0;
      end else begin
        acc_d   = acc_sum;
        phase_d = phase_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clock_clk) begin
    if (!reset_sink_reset_n) begin
      acc_q   <= 14'd0;
      phase_q <= 2'd0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
    end
  end
`else
  assign cap_data = response_data;
  assign emit     = capture;
`endif

  assign conv_data = ({4'b0000, cap_data} - MID_CODE) << 4;

  // An untransferred sample wins over a fresh one unless it leaves in this same cycle.
  always_comb begin
    sample_valid_d = sample_valid_q;
    sample_data_d  = sample_data_q;
    drop           = 1'b0;
    if (emit) begin
      if (sample_valid_q && !sample_ready) begin
        drop = 1'b1;
      end else begin
        sample_valid_d = 1'b1;
        sample_data_d  = conv_data;
      end
    end else if (sample_valid_q && sample_ready) begin
      sample_valid_d = 1'b0;
    end

    lost_tick = tick && (state_q != S_IDLE);
    overrun_d = overrun_q && !err_clr;
    if (lost_tick || drop) overrun_d = 1'b1;
    timeout_d = timeout_q && !err_clr;
    if (wait_expired) timeout_d = 1'b1;
  end

  always_ff @(posedge clock_clk) begin
    if (!reset_sink_reset_n) begin
      state_q        <= S_IDLE;
      tick_cnt_q     <= 16'd0;
      wait_cnt_q     <= 16'd0;
      sample_valid_q <= 1'b0;
      sample_data_q  <= 16'd0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      sample_valid_q <= sample_valid_d;
      sample_data_q  <= sample_data_d;
      overrun_q      <= overrun_d;
      timeout_q      <= timeout_d;
    end
  end

  assign command_valid         = (state_q == S_ISSUE);
  assign command_startofpacket = command_valid;
  assign command_endofpacket   = command_valid;
  assign command_channel       = CHANNEL;
  assign sample_valid          = sample_valid_q;
  assign sample_data           = sample_data_q;
  assign overrun               = overrun_q;
  assign timeout_err           = timeout_q;

endmodule
